// File: rtl/id_stage_p.sv
// Pipelined MIPS-style instruction decode stage: clocked register file with
// write-first bypass, immediate extension, load-use hazard detection and an
// ID/EX output register under a valid/ready handshake with flush.
module id_stage_p #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned REG_SIZE      = 32,
  parameter int unsigned REGADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_WIDTH-1:0]    ir,
  input  logic                     reg_wrt,
  input  logic [REGADDR_WIDTH-1:0] wrt_reg,
  input  logic [WORD_WIDTH-1:0]    wrt_dt,
  input  logic                     ex_mem_read,
  input  logic [REGADDR_WIDTH-1:0] ex_rt,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    read_data1,
  output logic [WORD_WIDTH-1:0]    read_data2,
  output logic [WORD_WIDTH-1:0]    offset,
  output logic [REGADDR_WIDTH-1:0] rt,
  output logic [REGADDR_WIDTH-1:0] rd,
  output logic [5:0]               opcode,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic                     hazard
);

  localparam bit ZR = (ZERO_REG != 0);

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  logic [WORD_WIDTH-1:0] regs [REG_SIZE];

  // Raw instruction fields.
  logic [5:0]               f_opcode;
  logic [REGADDR_WIDTH-1:0] f_rs;
  logic [REGADDR_WIDTH-1:0] f_rt;
  logic [REGADDR_WIDTH-1:0] f_rd;
  logic [4:0]               f_shamt;
  logic [5:0]               f_funct;
  logic [15:0]              f_imm;

  assign f_opcode = ir[31:26];
  assign f_rs     = ir[25:21];
  assign f_rt     = ir[20:16];
  assign f_rd     = ir[15:11];
  assign f_shamt  = ir[10:6];
  assign f_funct  = ir[5:0];
  assign f_imm    = ir[15:0];

  // An index that hits the hardwired zero register never writes or bypasses.
  logic wrt_en;
  assign wrt_en = reg_wrt && !(ZR && wrt_reg == '0);

  // Operand reads with write-first bypass from the same-cycle write-back.
  logic [WORD_WIDTH-1:0] op1;
  logic [WORD_WIDTH-1:0] op2;
  assign op1 = (ZR && f_rs == '0)          ? '0     :
               (wrt_en && wrt_reg == f_rs) ? wrt_dt : regs[f_rs];
  assign op2 = (ZR && f_rt == '0)          ? '0     :
               (wrt_en && wrt_reg == f_rt) ? wrt_dt : regs[f_rt];

  // Logical immediates zero-extend; everything else sign-extends.
  logic                  zext;
  logic [WORD_WIDTH-1:0] imm_ext;
  assign zext    = (f_opcode == OP_ANDI) || (f_opcode == OP_ORI) || (f_opcode == OP_XORI);
  assign imm_ext = {{(WORD_WIDTH-16){f_imm[15] & ~zext}}, f_imm};

  // Load-use stall and handshake; the stall is purely combinational.
  logic accept;
  assign hazard   = in_valid && ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == f_rs) || (ex_rt == f_rt));
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Register file: async clear, write on the rising edge.
  // NOTE: the storage array is reset because every entry must read as zero
  // after reset; this prevents mapping it onto a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_SIZE); i++) regs[i] <= '0;
    end else if (wrt_en) begin
      // NOTE: all state updates use non-blocking assignment so every
      // reader in this cycle sees the pre-edge value.
      regs[wrt_reg] <= wrt_dt;
    end
  end

  // ID/EX register: flush beats accept, accept loads, consume empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      read_data1 <= '0;
      read_data2 <= '0;
      offset     <= '0;
      rt         <= '0;
      rd         <= '0;
      opcode     <= '0;
      shamt      <= '0;
      funct      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      read_data1 <= op1;
      read_data2 <= op2;
      offset     <= imm_ext;
      rt         <= f_rt;
      rd         <= f_rd;
      opcode     <= f_opcode;
      shamt      <= f_shamt;
      funct      <= f_funct;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_p.sv
// Directed testbench for id_stage_p: register file, bypass, extension,
// load-use stall, backpressure, flush and asynchronous reset.
module tb_id_stage_p;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ir;
  logic        reg_wrt;
  logic [4:0]  wrt_reg;
  logic [31:0] wrt_dt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] offset;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  opcode;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic        hazard;

  int checks = 0;
  int errors = 0;

  id_stage_p dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
    .reg_wrt(reg_wrt), .wrt_reg(wrt_reg), .wrt_dt(wrt_dt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .read_data1(read_data1), .read_data2(read_data2), .offset(offset),
    .rt(rt), .rd(rd), .opcode(opcode), .shamt(shamt), .funct(funct),
    .hazard(hazard)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ir = '0; reg_wrt = 1'b0; wrt_reg = '0;
    wrt_dt = '0; ex_mem_read = 1'b0; ex_rt = '0; flush = 1'b0; out_ready = 1'b1;
    #2;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_read_data1", read_data1, 32'd0);
    check("reset_offset", offset, 32'd0);
    check("reset_opcode", {26'd0, opcode}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write r5, then read it back through rs.
    reg_wrt = 1'b1; wrt_reg = 5'd5; wrt_dt = 32'h0000_1234;
    tick();
    reg_wrt = 1'b0; in_valid = 1'b1; ir = 32'h00A0_0000;
    #1 check("r5_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("r5_out_valid", {31'd0, out_valid}, 32'd1);
    check("r5_read_data1", read_data1, 32'h0000_1234);

    // Same-cycle bypass on rt=7.
    reg_wrt = 1'b1; wrt_reg = 5'd7; wrt_dt = 32'hDEAD_BEEF; ir = 32'h0007_0000;
    tick();
    check("bypass_read_data2", read_data2, 32'hDEAD_BEEF);
    check("bypass_rt", {27'd0, rt}, 32'd7);

    // Writing r0 is ignored, including the bypass path.
    wrt_reg = 5'd0; wrt_dt = 32'hFFFF_FFFF; ir = 32'h0000_0000;
    tick();
    check("r0_bypass_rd1", read_data1, 32'd0);
    check("r0_bypass_rd2", read_data2, 32'd0);
    reg_wrt = 1'b0; ir = 32'h00E0_0000;
    tick();
    check("r7_stored", read_data1, 32'hDEAD_BEEF);
    check("r0_stored", read_data2, 32'd0);

    // Immediate extension.
    ir = 32'h2001_8000; tick();
    check("addi_offset", offset, 32'hFFFF_8000);
    check("addi_opcode", {26'd0, opcode}, 32'h08);
    ir = 32'h3401_8000; tick();
    check("ori_offset", offset, 32'h0000_8000);
    ir = 32'h3001_8000; tick();
    check("andi_offset", offset, 32'h0000_8000);
    ir = 32'h3801_8000; tick();
    check("xori_offset", offset, 32'h0000_8000);
    ir = 32'h2801_8000; tick();
    check("slti_offset", offset, 32'hFFFF_8000);
    ir = 32'h2001_7FFF; tick();
    check("addi_pos_offset", offset, 32'h0000_7FFF);

    // R-type field decode: rs=9 rt=3 rd=10 shamt=11 funct=0x22.
    ir = {6'd0, 5'd9, 5'd3, 5'd10, 5'd11, 6'h22}; tick();
    check("rtype_rd", {27'd0, rd}, 32'd10);
    check("rtype_shamt", {27'd0, shamt}, 32'd11);
    check("rtype_funct", {26'd0, funct}, 32'h22);
    check("rtype_offset", offset, 32'h0000_52E2);

    // Hazard qualifiers: ex_rt=0 never stalls, rt match stalls.
    ex_mem_read = 1'b1; ex_rt = 5'd0; ir = 32'h0000_0000;
    #1 check("hazard_ex_rt0", {31'd0, hazard}, 32'd0);
    ex_rt = 5'd3; ir = 32'h0003_0000;
    #1 check("hazard_rt_match", {31'd0, hazard}, 32'd1);
    in_valid = 1'b0;
    #1 check("hazard_no_valid", {31'd0, hazard}, 32'd0);

    // Load-use on rs=3 with a concurrent write-back of r3.
    in_valid = 1'b1; ir = 32'h0060_0000;
    reg_wrt = 1'b1; wrt_reg = 5'd3; wrt_dt = 32'h0000_0055;
    #1;
    check("loaduse_hazard", {31'd0, hazard}, 32'd1);
    check("loaduse_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("loaduse_bubble", {31'd0, out_valid}, 32'd0);
    reg_wrt = 1'b0; ex_mem_read = 1'b0;
    #1 check("loaduse_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("loaduse_accept_valid", {31'd0, out_valid}, 32'd1);
    check("loaduse_accept_rd1", read_data1, 32'h0000_0055);

    // Backpressure: three cycles of out_ready=0 hold the register.
    out_ready = 1'b0; ir = 32'h3401_1111;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_read_data1", read_data1, 32'h0000_0055);
      check("bp_offset", offset, 32'd0);
    end

    // Flush under backpressure, with a register write in the same cycle.
    flush = 1'b1; reg_wrt = 1'b1; wrt_reg = 5'd1; wrt_dt = 32'h0000_A5A5;
    #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; reg_wrt = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("flush_no_accept_valid", {31'd0, out_valid}, 32'd0);
    check("flush_no_accept_offset", offset, 32'd0);

    // r1 written during the flush cycle is readable.
    in_valid = 1'b1; ir = 32'h0020_0000;
    tick();
    check("r1_written", read_data1, 32'h0000_A5A5);
    check("r1_out_valid", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_read_data1", read_data1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_r1", read_data1, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
